// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for one ALU instruction on the bus datapath.
// Walks rb->Y, rc->ALU->Z, Z->ra (or Z->LO/HI). Outputs are decoded from the registered state.
module alu_op_sequencer #(
  parameter int         EXEC_CYCLES = 1,
  parameter logic [4:0] IDLE_SEL    = 5'd0
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [4:0] opcode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic [3:0] rc,
  output logic [4:0] reg_out_select,
  output logic [3:0] reg_in_sel,
  output logic       reg_in_en,
  output logic       y_in,
  output logic       z_in,
  output logic       hi_in,
  output logic       lo_in,
  output logic [4:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;

  localparam logic [4:0] SEL_ZHI = 5'd18;
  localparam logic [4:0] SEL_ZLO = 5'd19;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_Y, S_EXEC, S_WB_LO, S_WB_HI, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [4:0]      op_q;
  logic [3:0]      ra_q, rb_q, rc_q;
  logic            err_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   last_cnt;
  logic            exec_last;
  logic            accept;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_MUL, OP_DIV, OP_NEG, OP_NOT: is_legal = 1'b1;
      default:                        is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    is_unary = (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_long(input logic [4:0] op);
    is_long = (op == OP_MUL) || (op == OP_DIV);
  endfunction

  assign accept    = (state == S_IDLE) && start;
  assign last_cnt  = is_long(op_q) ? CW'(EXEC_CYCLES - 1) : '0;
  assign exec_last = (cnt == last_cnt);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Instruction fields are frozen at accept so later input changes cannot disturb the op.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        op_q  <= opcode;
        ra_q  <= ra;
        rb_q  <= rb;
        rc_q  <= rc;
        err_q <= ~is_legal(opcode);
      end
      if ((state == S_EXEC) && !exec_last) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!is_legal(opcode))     state_nxt = S_DONE;
          else if (is_unary(opcode)) state_nxt = S_EXEC;
          else                       state_nxt = S_LOAD_Y;
        end
      end
      S_LOAD_Y: state_nxt = S_EXEC;
      S_EXEC:   if (exec_last) state_nxt = S_WB_LO;
      S_WB_LO:  state_nxt = is_long(op_q) ? S_WB_HI : S_DONE;
      S_WB_HI:  state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    reg_out_select = IDLE_SEL;
    reg_in_en      = 1'b0;
    y_in           = 1'b0;
    z_in           = 1'b0;
    hi_in          = 1'b0;
    lo_in          = 1'b0;
    busy           = (state != S_IDLE);
    done           = (state == S_DONE);
    case (state)
      S_LOAD_Y: begin
        reg_out_select = {1'b0, rb_q};
        y_in           = 1'b1;
      end
      S_EXEC: begin
        reg_out_select = is_unary(op_q) ? {1'b0, rb_q} : {1'b0, rc_q};
        z_in           = exec_last;
      end
      S_WB_LO: begin
        reg_out_select = SEL_ZLO;
        if (is_long(op_q)) lo_in = 1'b1;
        else               reg_in_en = 1'b1;
      end
      S_WB_HI: begin
        reg_out_select = SEL_ZHI;
        hi_in          = 1'b1;
      end
      default: ;
    endcase
  end

  assign reg_in_sel = ra_q;
  assign alu_op     = op_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench: drives instructions into the sequencer, models the bus datapath it controls,
// and scores each op at its done pulse against expectations queued at issue time.
module tb_alu_op_sequencer;

  localparam int         EXEC_N = 3;
  localparam logic [4:0] ISEL   = 5'd0;

  logic       clock, clear, start;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic [4:0] reg_out_select;
  logic [3:0] reg_in_sel;
  logic       reg_in_en, y_in, z_in, hi_in, lo_in;
  logic [4:0] alu_op;
  logic       busy, done, err;

  alu_op_sequencer #(.EXEC_CYCLES(EXEC_N), .IDLE_SEL(ISEL)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc), .reg_out_select(reg_out_select),
    .reg_in_sel(reg_in_sel), .reg_in_en(reg_in_en), .y_in(y_in), .z_in(z_in),
    .hi_in(hi_in), .lo_in(lo_in), .alu_op(alu_op), .busy(busy), .done(done), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          lat;
    logic        err;
    int          ny;
    int          nz;
    int          zpos;
    int          nwr;
    int          nhl;
    int          kind;   // 0: no result, 1: register, 2: HI/LO
    logic [3:0]  dest;
    logic [31:0] val;
    logic [31:0] hi;
  } exp_t;

  exp_t sb[$];

  logic [31:0] R [16];
  logic [31:0] Y, HI, LO;
  logic [63:0] Z;
  int checks = 0;
  int errors = 0;
  int lat = 0, ny = 0, nz = 0, zpos = 0, nwr = 0, nhl = 0, enmax = 0;

  function automatic logic [31:0] bus_val(input logic [4:0] s);
    if (s < 5'd16) return R[s[3:0]];
    case (s)
      5'd16:   return HI;
      5'd17:   return LO;
      5'd18:   return Z[63:32];
      5'd19:   return Z[31:0];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    case (op)
      5'd3:  return {32'h0, a + b};
      5'd4:  return {32'h0, a - b};
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd7:  begin t = {a, a} >> b[4:0]; return {32'h0, t[31:0]}; end
      5'd8:  begin t = {a, a} << b[4:0]; return {32'h0, t[63:32]}; end
      5'd9:  return {32'h0, a >> b[4:0]};
      5'd10: return {32'h0, $signed(a) >>> b[4:0]};
      5'd11: return {32'h0, a << b[4:0]};
      5'd15: return {32'h0, a} * {32'h0, b};
      5'd16: return (b == 0) ? 64'h0 : {a % b, a / b};
      5'd17: return {32'h0, -b};
      5'd18: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  // Datapath model plus per-op event recording; outputs are stable at the falling edge.
  always @(negedge clock) begin
    logic [31:0] b;
    int ne;
    exp_t e;
    if (clear) begin
      lat = 0; ny = 0; nz = 0; zpos = 0; nwr = 0; nhl = 0; enmax = 0;
    end else begin
      b = bus_val(reg_out_select);
      if (y_in) Y = b;
      if (z_in) Z = alu(alu_op, Y, b);
      if (reg_in_en) R[reg_in_sel] = b;
      if (hi_in) HI = b;
      if (lo_in) LO = b;
      ne = int'(y_in) + int'(z_in) + int'(reg_in_en) + int'(hi_in) + int'(lo_in);
      if (ne > enmax) enmax = ne;
      if (busy) lat++;
      if (y_in) ny++;
      if (z_in) begin nz++; zpos = lat; end
      if (reg_in_en) nwr++;
      if (hi_in || lo_in) nhl++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done with empty queue, required none");
        end else begin
          e = sb.pop_front();
          checks++; if (lat !== e.lat) begin errors++; $display("FAIL latency: got %0d required %0d", lat, e.lat); end
          checks++; if (err !== e.err) begin errors++; $display("FAIL err_at_done: got %0b required %0b", err, e.err); end
          checks++; if (ny !== e.ny) begin errors++; $display("FAIL y_in_cycles: got %0d required %0d", ny, e.ny); end
          checks++; if (nz !== e.nz) begin errors++; $display("FAIL z_in_cycles: got %0d required %0d", nz, e.nz); end
          if (e.nz > 0) begin
            checks++; if (zpos !== e.zpos) begin errors++; $display("FAIL z_in_position: got %0d required %0d", zpos, e.zpos); end
          end
          checks++; if (nwr !== e.nwr) begin errors++; $display("FAIL reg_in_en_cycles: got %0d required %0d", nwr, e.nwr); end
          checks++; if (nhl !== e.nhl) begin errors++; $display("FAIL hilo_cycles: got %0d required %0d", nhl, e.nhl); end
          checks++; if (enmax > 1) begin errors++; $display("FAIL one_enable: got %0d simultaneous required <=1", enmax); end
          checks++; if (reg_in_sel !== e.dest) begin errors++; $display("FAIL reg_in_sel: got %0d required %0d", reg_in_sel, e.dest); end
          if (e.kind == 1) begin
            checks++; if (R[e.dest] !== e.val) begin errors++; $display("FAIL reg_result: R%0d got %h required %h", e.dest, R[e.dest], e.val); end
          end else if (e.kind == 2) begin
            checks++; if (LO !== e.val) begin errors++; $display("FAIL lo_result: got %h required %h", LO, e.val); end
            checks++; if (HI !== e.hi) begin errors++; $display("FAIL hi_result: got %h required %h", HI, e.hi); end
          end
        end
        lat = 0; ny = 0; nz = 0; zpos = 0; nwr = 0; nhl = 0; enmax = 0;
      end
    end
  end

  function automatic exp_t make_exp(input logic [4:0] op, input logic [3:0] a, input int kind,
                                    input logic [31:0] val, input logic [31:0] hi);
    exp_t e;
    logic legal, unary, lng;
    legal = (op >= 5'd3 && op <= 5'd11) || (op >= 5'd15 && op <= 5'd18);
    unary = (op == 5'd17) || (op == 5'd18);
    lng   = (op == 5'd15) || (op == 5'd16);
    e.lat  = !legal ? 1 : unary ? 3 : lng ? 4 + EXEC_N : 4;
    e.err  = !legal;
    e.ny   = (legal && !unary) ? 1 : 0;
    e.nz   = legal ? 1 : 0;
    e.zpos = unary ? 1 : lng ? 1 + EXEC_N : 2;
    e.nwr  = (legal && !lng) ? 1 : 0;
    e.nhl  = lng ? 2 : 0;
    e.kind = kind;
    e.dest = a;
    e.val  = val;
    e.hi   = hi;
    return e;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input int kind, input logic [31:0] val, input logic [31:0] hi, input bit keep);
    @(negedge clock);
    opcode = op; ra = a; rb = b; rc = c; start = 1'b1;
    sb.push_back(make_exp(op, a, kind, val, hi));
    @(negedge clock);
    if (!keep) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", budget);
    end
  endtask

  task automatic test_reset;
    clear = 1'b1; start = 1'b0; opcode = 5'd0; ra = 4'd0; rb = 4'd0; rc = 4'd0;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    clear = 1'b0;
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    checks++; if (reg_out_select !== ISEL) begin errors++; $display("FAIL reset_sel: got %0d required %0d", reg_out_select, ISEL); end
    checks++; if ({reg_in_en, y_in, z_in, hi_in, lo_in} !== 5'b0) begin
      errors++; $display("FAIL reset_enables: got %b required 00000", {reg_in_en, y_in, z_in, hi_in, lo_in});
    end
    checks++; if (alu_op !== 5'd0 || reg_in_sel !== 4'd0) begin
      errors++; $display("FAIL reset_fields: got op=%0d sel=%0d required 0/0", alu_op, reg_in_sel);
    end
  endtask

  task automatic test_add;
    issue(5'd3, 4'd3, 4'd1, 4'd2, 1, 32'd12, 32'd0, 1'b0);
    checks++; if (reg_out_select !== 5'd1 || y_in !== 1'b1) begin
      errors++; $display("FAIL add_load_y: got sel=%0d y_in=%b required 1/1", reg_out_select, y_in);
    end
    @(negedge clock);
    checks++; if (reg_out_select !== 5'd2 || z_in !== 1'b1 || alu_op !== 5'd3) begin
      errors++; $display("FAIL add_exec: got sel=%0d z_in=%b op=%0d required 2/1/3", reg_out_select, z_in, alu_op);
    end
    @(negedge clock);
    checks++; if (reg_out_select !== 5'd19 || reg_in_en !== 1'b1 || reg_in_sel !== 4'd3) begin
      errors++; $display("FAIL add_wb: got sel=%0d en=%b dst=%0d required 19/1/3", reg_out_select, reg_in_en, reg_in_sel);
    end
    wait_done(10);
  endtask

  task automatic test_neg;
    issue(5'd17, 4'd4, 4'd5, 4'd9, 1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    checks++; if (reg_out_select !== 5'd5 || z_in !== 1'b1 || y_in !== 1'b0) begin
      errors++; $display("FAIL neg_exec: got sel=%0d z_in=%b y_in=%b required 5/1/0", reg_out_select, z_in, y_in);
    end
    wait_done(10);
  endtask

  task automatic test_mul;
    issue(5'd15, 4'd2, 4'd6, 4'd7, 2, 32'd0, 32'd1, 1'b0);
    wait_done(20);
  endtask

  task automatic test_illegal;
    issue(5'd31, 4'd3, 4'd1, 4'd2, 0, 32'd0, 32'd0, 1'b0);
    wait_done(5);
    @(negedge clock);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_held: got err=%b busy=%b required 1/0", err, busy);
    end
    issue(5'd5, 4'd13, 4'd1, 4'd2, 1, 32'd5, 32'd0, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b required 0", err); end
    wait_done(10);
  endtask

  task automatic test_misc_ops;
    issue(5'd11, 4'd14, 4'd1, 4'd5, 1, 32'd10, 32'd0, 1'b0);         wait_done(10);
    issue(5'd18, 4'd15, 4'd2, 4'd0, 1, 32'hFFFF_FFF8, 32'd0, 1'b0);  wait_done(10);
    issue(5'd7, 4'd0, 4'd5, 4'd5, 1, 32'h8000_0000, 32'd0, 1'b0);    wait_done(10);
    issue(5'd16, 4'd1, 4'd11, 4'd12, 2, 32'd14, 32'd2, 1'b0);        wait_done(20);
  endtask

  task automatic test_back_to_back;
    issue(5'd3, 4'd9, 4'd1, 4'd2, 1, 32'd12, 32'd0, 1'b1);
    opcode = 5'd4; ra = 4'd10;
    wait_done(10);
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b required 0", busy); end
    sb.push_back(make_exp(5'd4, 4'd10, 1, 32'hFFFF_FFFE, 32'd0));
    @(negedge clock);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || alu_op !== 5'd4) begin
      errors++; $display("FAIL b2b_second_accept: got busy=%b op=%0d required 1/4", busy, alu_op);
    end
    wait_done(10);
    checks++; if (R[10] !== 32'hFFFF_FFFE || R[9] !== 32'd12) begin
      errors++; $display("FAIL b2b_results: got R9=%h R10=%h required 0000000c/fffffffe", R[9], R[10]);
    end
  endtask

  task automatic test_clear_mid_op;
    int n;
    issue(5'd4, 4'd8, 4'd1, 4'd2, 1, 32'hFFFF_FFFE, 32'd0, 1'b0);
    n = 0;
    while (!z_in && n < 10) begin @(negedge clock); n++; end
    checks++; if (z_in !== 1'b1) begin errors++; $display("FAIL clear_reach_exec: got z_in=%b required 1", z_in); end
    #1 clear = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL clear_status: got busy=%b done=%b err=%b required 0/0/0", busy, done, err);
    end
    checks++; if ({reg_in_en, y_in, z_in, hi_in, lo_in} !== 5'b0 || reg_out_select !== ISEL) begin
      errors++; $display("FAIL clear_outputs: got en=%b sel=%0d required 00000/%0d",
                         {reg_in_en, y_in, z_in, hi_in, lo_in}, reg_out_select, ISEL);
    end
    sb.delete();
    repeat (2) @(negedge clock);
    clear = 1'b0;
    repeat (4) @(negedge clock);
    checks++; if (R[8] !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      errors++; $display("FAIL clear_no_write: got R8=%h busy=%b required deadbeef/0", R[8], busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) R[i] = 32'h0;
    R[1] = 32'd5; R[2] = 32'd7; R[5] = 32'd1; R[6] = 32'h1_0000; R[7] = 32'h1_0000;
    R[8] = 32'hDEAD_BEEF; R[11] = 32'd100; R[12] = 32'd7;
    Y = 32'h0; HI = 32'h0; LO = 32'h0; Z = 64'h0;
    test_reset();
    test_add();
    test_neg();
    test_mul();
    test_illegal();
    test_misc_ops();
    test_back_to_back();
    test_clear_mid_op();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
